// File: rtl/mux_8x1.sv
// ---------------------------------------------------------------------------
// mux_8x1
//
// Registered 8-to-1 multiplexer. The 3-bit select {S2,S1,S0} picks one of
// the eight data inputs D0..D7. The chosen word is captured on the rising
// clock edge whenever en is high and is then driven on out. sel_q reports
// the select code that produced the current out.
//
// Parameters:
//   WIDTH      - bit width of D0..D7, out and out_comb (1..64)
//   RESET_VAL  - value loaded into out while rst_n is low; only the low
//                WIDTH bits are used, so the value is zero-extended or
//                truncated to WIDTH
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   en        in   1      capture enable (1 = update, 0 = hold)
//   D0..D7    in   WIDTH  data inputs, Dn selected when {S2,S1,S0} == n
//   S0,S1,S2  in   1      select bits, S2 is the MSB
//   out       out  WIDTH  registered selected data
//   sel_q     out  3      registered select code behind the current out
//   out_comb  out  WIDTH  unregistered D[{S2,S1,S0}]; only present when
//                         MUX_8X1_COMB_OUT_EN is defined
//
// Build option:
//   MUX_8X1_COMB_OUT_EN - adds the out_comb port for zero-latency
//                         observation of the selected input.
// ---------------------------------------------------------------------------
module mux_8x1 #(
    parameter int          WIDTH     = 1,
    parameter logic [63:0] RESET_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
`ifdef MUX_8X1_COMB_OUT_EN
    output logic [WIDTH-1:0] out_comb,
`endif
    output logic [WIDTH-1:0] out,
    output logic [2:0]       sel_q
);

    localparam logic [WIDTH-1:0] RST_OUT = RESET_VAL[WIDTH-1:0];

    logic [2:0]       sel;
    logic [WIDTH-1:0] mux_d;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic [2:0]       sel_d;

    assign sel = {S2, S1, S0};

    // Every one of the eight codes has its own arm. The default arm is only
    // reachable when a select bit is X/Z, and then it poisons the result so
    // that an unknown select is visible on out in simulation.
    always_comb begin
        mux_d = {WIDTH{1'b0}};
        case (sel)
            3'b000:  mux_d = D0;
            3'b001:  mux_d = D1;
            3'b010:  mux_d = D2;
            3'b011:  mux_d = D3;
            3'b100:  mux_d = D4;
            3'b101:  mux_d = D5;
            3'b110:  mux_d = D6;
            3'b111:  mux_d = D7;
            default: mux_d = {WIDTH{1'bx}};
        endcase
    end

    // Next-state: capture the selected word and the raw select code when
    // enabled, otherwise hold both so that out and sel_q stay consistent.
    always_comb begin
        out_d = out_q;
        sel_d = sel_q;
        if (en) begin
            out_d = mux_d;
            sel_d = sel;
        end
    end

    // Reset acts immediately and overrides en, so a pending capture in the
    // same cycle is discarded as a whole rather than partially applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= RST_OUT;
            sel_q <= 3'b000;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
        end
    end

    assign out = out_q;

`ifdef MUX_8X1_COMB_OUT_EN
    assign out_comb = mux_d;
`endif

endmodule

// File: tb/tb_mux_8x1.sv
// ---------------------------------------------------------------------------
// tb_mux_8x1
//
// Testbench for mux_8x1. Two instances share clock, reset, enable and
// select: dut1 is 1 bit wide with a zero reset value, dut8 is 8 bits wide
// with RESET_VAL = 8'h3C. dut8's inputs default to a one-hot pattern
// (Dn = 1 << n), so a wrong select index shows up as a wrong bit.
// ---------------------------------------------------------------------------
module tb_mux_8x1;

    typedef struct {
        logic       en;
        logic [2:0] sel;
        logic [7:0] d1_bits;
        logic       exp1;
        logic [7:0] exp8;
        logic [2:0] exp_sel;
    } vec_t;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic       en;
    logic       s0;
    logic       s1;
    logic       s2;
    logic [7:0] d1_bits;
    logic [7:0] d8 [8];

    logic       out1;
    logic [2:0] sel_q1;
    logic [7:0] out8;
    logic [2:0] sel_q8;
`ifdef MUX_8X1_COMB_OUT_EN
    logic       out_comb1;
    logic [7:0] out_comb8;
`endif

    int   checks;
    int   failures;
    vec_t vecs[$];

    mux_8x1 #(
        .WIDTH(1),
        .RESET_VAL(64'd0)
    ) dut1 (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .D0(d1_bits[0]),
        .D1(d1_bits[1]),
        .D2(d1_bits[2]),
        .D3(d1_bits[3]),
        .D4(d1_bits[4]),
        .D5(d1_bits[5]),
        .D6(d1_bits[6]),
        .D7(d1_bits[7]),
        .S0(s0),
        .S1(s1),
        .S2(s2),
`ifdef MUX_8X1_COMB_OUT_EN
        .out_comb(out_comb1),
`endif
        .out(out1),
        .sel_q(sel_q1)
    );

    mux_8x1 #(
        .WIDTH(8),
        .RESET_VAL(64'h3C)
    ) dut8 (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .D0(d8[0]),
        .D1(d8[1]),
        .D2(d8[2]),
        .D3(d8[3]),
        .D4(d8[4]),
        .D5(d8[5]),
        .D6(d8[6]),
        .D7(d8[7]),
        .S0(s0),
        .S1(s1),
        .S2(s2),
`ifdef MUX_8X1_COMB_OUT_EN
        .out_comb(out_comb8),
`endif
        .out(out8),
        .sel_q(sel_q8)
    );

    // The clock stays parked low until the reset-without-clock phase ends.
    initial begin
        clk = 1'b0;
        wait (clk_run === 1'b1);
        forever #5 clk = ~clk;
    end

    // Drives one table row onto the shared inputs.
    task automatic applyStimulus(input logic en_i, input logic [2:0] sel_i,
                                 input logic [7:0] bits_i);
        en      = en_i;
        {s2, s1, s0} = sel_i;
        d1_bits = bits_i;
    endtask

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic en_i, input logic [2:0] sel_i,
                           input logic [7:0] bits_i, input logic exp1_i,
                           input logic [7:0] exp8_i, input logic [2:0] exp_sel_i);
        vec_t v;
        v.en      = en_i;
        v.sel     = sel_i;
        v.d1_bits = bits_i;
        v.exp1    = exp1_i;
        v.exp8    = exp8_i;
        v.exp_sel = exp_sel_i;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk_run  = 1'b0;
        rst_n    = 1'b1;
        en       = 1'b0;
        {s2, s1, s0} = 3'b000;
        d1_bits  = 8'h00;
        for (int i = 0; i < 8; i++) d8[i] = 8'(1 << i);

        // Sweep the A5 pattern across all eight codes.
        add_vec(1'b1, 3'd0, 8'hA5, 1'b1, 8'h01, 3'd0);
        add_vec(1'b1, 3'd1, 8'hA5, 1'b0, 8'h02, 3'd1);
        add_vec(1'b1, 3'd2, 8'hA5, 1'b1, 8'h04, 3'd2);
        add_vec(1'b1, 3'd3, 8'hA5, 1'b0, 8'h08, 3'd3);
        add_vec(1'b1, 3'd4, 8'hA5, 1'b0, 8'h10, 3'd4);
        add_vec(1'b1, 3'd5, 8'hA5, 1'b1, 8'h20, 3'd5);
        add_vec(1'b1, 3'd6, 8'hA5, 1'b0, 8'h40, 3'd6);
        add_vec(1'b1, 3'd7, 8'hA5, 1'b1, 8'h80, 3'd7);
        // A different bit pattern on a couple of codes.
        add_vec(1'b1, 3'd6, 8'h5A, 1'b1, 8'h40, 3'd6);
        add_vec(1'b1, 3'd1, 8'h5A, 1'b1, 8'h02, 3'd1);
        // Capture D3=1, then hold for three clocks while the inputs move.
        add_vec(1'b1, 3'd3, 8'h08, 1'b1, 8'h08, 3'd3);
        add_vec(1'b0, 3'd0, 8'h00, 1'b1, 8'h08, 3'd3);
        add_vec(1'b0, 3'd0, 8'h00, 1'b1, 8'h08, 3'd3);
        add_vec(1'b0, 3'd0, 8'h00, 1'b1, 8'h08, 3'd3);
        // Re-enable: out picks up D0 on the next edge.
        add_vec(1'b1, 3'd0, 8'h00, 1'b0, 8'h01, 3'd0);

        // Reset with no clock while data and select move around.
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            d1_bits = (i % 2 == 0) ? 8'hFF : 8'h00;
            {s2, s1, s0} = 3'(i + 3);
            en = 1'b1;
            #1;
            checkOutput("reset_out1", {7'd0, out1}, 8'h00);
            checkOutput("reset_out8", out8, 8'h3C);
            checkOutput("reset_sel_q", {5'd0, sel_q8}, 8'h00);
        end
`ifdef MUX_8X1_COMB_OUT_EN
        d1_bits = 8'h20;
        {s2, s1, s0} = 3'b101;
        #1;
        checkOutput("comb_during_reset", {7'd0, out_comb1}, 8'h01);
`endif

        // Release reset while the clock is still parked, then start it.
        applyStimulus(1'b0, 3'd0, 8'h00);
        #2 rst_n = 1'b1;
        #2 clk_run = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].en, vecs[k].sel, vecs[k].d1_bits);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_out1", k), {7'd0, out1}, {7'd0, vecs[k].exp1});
            checkOutput($sformatf("vec%0d_out8", k), out8, vecs[k].exp8);
            checkOutput($sformatf("vec%0d_sel_q", k), {5'd0, sel_q1}, {5'd0, vecs[k].exp_sel});
        end

        // Between-edge activity: only the values present at the edge count.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            d1_bits[7] = ~d1_bits[7];
            s2 = ~s2;
            #1;
            checkOutput("between_edges_stable", {7'd0, out1}, 8'h00);
        end
        d1_bits = 8'h80;
        {s2, s1, s0} = 3'b111;
        @(posedge clk);
        #1;
        checkOutput("between_edges_out1", {7'd0, out1}, 8'h01);
        checkOutput("between_edges_out8", out8, 8'h80);
        checkOutput("between_edges_sel_q", {5'd0, sel_q8}, 8'h07);

        // Mid-operation reset with en still high.
        @(negedge clk);
        d8[7] = 8'hFF;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_out8", out8, 8'hFF);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_out8", out8, 8'h3C);
        checkOutput("mid_reset_out1", {7'd0, out1}, 8'h00);
        checkOutput("mid_reset_sel_q", {5'd0, sel_q8}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held_out8", out8, 8'h3C);
        checkOutput("reset_held_sel_q", {5'd0, sel_q1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_out8", out8, 8'hFF);
        checkOutput("post_reset_sel_q", {5'd0, sel_q8}, 8'h07);
        d8[7] = 8'h80;

`ifdef MUX_8X1_COMB_OUT_EN
        // Combinational output follows the select without a clock edge.
        @(negedge clk);
        applyStimulus(1'b1, 3'b101, 8'h20);
        #1;
        checkOutput("comb_out1", {7'd0, out_comb1}, 8'h01);
        checkOutput("comb_out8", out_comb8, 8'h20);
        checkOutput("comb_reg_lags", out8, 8'hFF);
        @(posedge clk);
        #1;
        checkOutput("comb_then_reg_out1", {7'd0, out1}, 8'h01);
        checkOutput("comb_then_reg_out8", out8, 8'h20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_8x1.md
Name: mux_8x1

Overview:
- Registered 8-to-1 multiplexer: selects one of eight data inputs D0..D7 using a 3-bit select formed from S2 (MSB), S1 and S0 (LSB).
- The result is captured on the rising clock edge and driven on out.
- Used as a generic datapath/selection primitive wherever a glitch-free, registered selection of eight sources is required.

Parameters:
- WIDTH, 1, bit width of each data input D0..D7 and of out (legal range 1..64).
- RESET_VAL, 0, value loaded into out during reset; width WIDTH, zero-extended or truncated to WIDTH.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronised by the integrator.
- en  input  1  capture enable; 1 = update registers this edge, 0 = hold.
- D0  input  WIDTH  data input, selected when {S2,S1,S0}=3'b000.
- D1  input  WIDTH  data input, selected for 3'b001.
- D2  input  WIDTH  data input, selected for 3'b010.
- D3  input  WIDTH  data input, selected for 3'b011.
- D4  input  WIDTH  data input, selected for 3'b100.
- D5  input  WIDTH  data input, selected for 3'b101.
- D6  input  WIDTH  data input, selected for 3'b110.
- D7  input  WIDTH  data input, selected for 3'b111.
- S0  input  1  select bit 0 (LSB).
- S1  input  1  select bit 1.
- S2  input  1  select bit 2 (MSB).
- out  output  WIDTH  registered selected data.
- sel_q  output  3  registered copy of {S2,S1,S0} that produced the current out.

Behaviour:
- Select index sel = {S2,S1,S0}; the combinational next value is D[sel], with all eight codes decoded and no default-only cases.
- On the rising edge of clk, if rst_n=1 and en=1: out <= D[sel]; sel_q <= sel.
- On the rising edge with en=0: out and sel_q hold their values.
- Latency: exactly 1 clock from a D/S change, sampled at an edge, to out.
- Reset: while rst_n=0, out=RESET_VAL and sel_q=3'b000 immediately, with no clock required. The first capture occurs on the first rising edge with rst_n=1 and en=1.
- Reset asserted mid-operation overrides en and any pending capture; there is no partial update.
- Simultaneous changes of data and select before an edge: the value sampled at the edge wins. Inputs changing between edges have no effect on out.
- No glitches on out: out changes only at a clock edge or on reset assertion.
- Width rule: pure selection, no arithmetic. Each bit of out comes from the same-numbered bit of the selected input.
- Simulation: an X or Z on any select bit at a capture edge drives out to all-X, and sel_q captures the raw bits.

Optional Feature:
- Macro MUX_8X1_COMB_OUT_EN.
- Defined: adds an output port out_comb (WIDTH) = D[{S2,S1,S0}] purely combinationally. It is unaffected by clk, en and rst_n, giving zero-latency observation alongside the registered out.
- Not defined: port out_comb does not exist. Only the registered out and sel_q are present, and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 with WIDTH=1 and D0..D7 toggling, no clock edges -> out=0, sel_q=000 immediately. Release rst_n, en=1 -> out follows D[sel] one edge later.
- Exhaustive select: D0..D7 = 8'hA5 bit pattern (D0=1, D1=0, D2=1, D3=0, D4=0, D5=1, D6=0, D7=1), step sel 0..7, one per clock -> out = 1,0,1,0,0,1,0,1 with 1-cycle lag; sel_q tracks 0..7.
- Hold: sel=3'b011, D3=1, capture, then en=0 and D3=0 plus sel=3'b000 for 3 clocks -> out stays 1, sel_q stays 011. Re-enable -> out=D0 next edge.
- Between-edge changes: toggle S2 and D7 several times within one clock period while only the final values are D7=1 and sel=111 at the edge -> out=1, with no intermediate change on out.
- Mid-operation reset: WIDTH=8, RESET_VAL=8'h3C, out=8'hFF, assert rst_n=0 between edges -> out=8'h3C instantly and holds while reset is low, regardless of en=1.
- Optional feature: with MUX_8X1_COMB_OUT_EN defined, D5=1 and the others 0, sel=101 -> out_comb=1 immediately with no clock and out=1 after the next edge. Without the macro, the module elaborates with no out_comb port.
